// File: rtl/tdm_mixer.sv
// Time-division mixer: sweeps the shared oscillator once per sample frame, sums
// the enabled voices, applies master volume and saturates into one held sample.
module tdm_mixer #(
  parameter int WIDTH       = 24,
  parameter int FRAC        = 8,
  parameter int N_OSC       = 16,
  parameter int OSC_LATENCY = 1,
  parameter int VOL_W       = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             frame_start,
  input  logic [N_OSC-1:0]                 osc_enable,
  input  logic signed [WIDTH+FRAC-1:0]     wave_in,
  input  logic [VOL_W-1:0]                 master_volume,
  output logic [$clog2(N_OSC)-1:0]         osc_index,
  output logic signed [WIDTH+FRAC-1:0]     out,
  output logic                             out_valid,
  output logic                             clip,
  output logic                             overrun,
  output logic [$clog2(N_OSC):0]           num_active
);

  localparam int SW = WIDTH + FRAC;
  localparam int AW = SW + $clog2(N_OSC) + 1;
  localparam int PW = AW + VOL_W + 1;
  localparam int IW = $clog2(N_OSC);
  localparam int CW = $clog2(N_OSC + OSC_LATENCY) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_SAT   = 2'd3;

  localparam logic [CW-1:0] LAT_C    = CW'(OSC_LATENCY);
  localparam logic [CW-1:0] LAST_C   = CW'(N_OSC + OSC_LATENCY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_OSC - 1);

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  // Drops the FRAC gain bits and clamps to the sample range; MSB of result flags a clamp.
  function automatic logic [SW:0] sat_word(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> FRAC;
    if (s > SAT_MAX)      sat_word = {1'b1, SAT_MAX[SW-1:0]};
    else if (s < SAT_MIN) sat_word = {1'b1, SAT_MIN[SW-1:0]};
    else                  sat_word = {1'b0, s[SW-1:0]};
  endfunction

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic signed [AW-1:0]    r_acc_p0;
  logic signed [PW-1:0]    r_prod_p1;
  logic [IW:0]             r_act;

  logic [CW-1:0]           w_sidx;
  logic                    w_take;
  logic                    w_en;
  logic signed [VOL_W:0]   w_vol;
  logic signed [SW-1:0]    w_sat;
  logic                    w_clip;

  // r_cnt counts SWEEP cycles; the wave arriving now belongs to index r_cnt-OSC_LATENCY.
  assign w_sidx = r_cnt - LAT_C;
  assign w_take = (r_cnt >= LAT_C);
  assign w_en   = |(osc_enable & (N_OSC'(1) << w_sidx));
  assign w_vol  = $signed({1'b0, master_volume});
  assign {w_clip, w_sat} = sat_word(r_prod_p1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc_p0   <= '0;
      r_prod_p1  <= '0;
      r_act      <= '0;
      osc_index  <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      clip       <= 1'b0;
      overrun    <= 1'b0;
      num_active <= '0;
    end else begin
      out_valid <= 1'b0;
      if (frame_start && (r_state != S_IDLE)) overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_acc_p0  <= '0;
            r_act     <= '0;
            r_cnt     <= '0;
            osc_index <= '0;
            r_state   <= S_SWEEP;
          end
        end
        // Accumulate stage
        S_SWEEP: begin
          if (w_take && w_en) begin
            r_acc_p0 <= r_acc_p0 + AW'(wave_in);
            r_act    <= r_act + 1'b1;
          end
          if (r_cnt == LAST_C) begin
            osc_index <= '0;
            r_state   <= S_SCALE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (osc_index != IDX_LAST) osc_index <= osc_index + 1'b1;
          end
        end
        // Gain stage
        S_SCALE: begin
          r_prod_p1 <= PW'(r_acc_p0) * PW'(w_vol);
          r_state   <= S_SAT;
        end
        // Saturate / output stage
        S_SAT: begin
          out        <= w_sat;
          clip       <= clip | w_clip;
          out_valid  <= 1'b1;
          num_active <= r_act;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tdm_mixer.md
Name: tdm_mixer

Overview:
- Time-division mixer between the shared oscillator and the pan stage.
- On each sample-frame start pulse, sweeps oscillator indices 0..N_OSC-1, one per clock, and accumulates the returned fixed-point waves.
- Applies master volume, saturates, and presents one held mixed sample per frame with a one-cycle valid strobe.
- Replaces the ad-hoc counter/accumulator logic currently in the top level.

Parameters:
- WIDTH, 24, sample integer width.
- FRAC, 8, fractional bits of wave/sample values (sample word is WIDTH+FRAC bits, signed).
- N_OSC, 16, oscillators swept per frame.
- OSC_LATENCY, 1, clocks from osc_index change to the matching wave_in.
- VOL_W, 16, master_volume width (unsigned, FRAC fractional bits).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse, start of sample frame
- osc_enable  in  N_OSC  per-oscillator enable mask (bit i = oscillator i)
- wave_in  in  WIDTH+FRAC  signed oscillator output for index issued OSC_LATENCY cycles earlier
- master_volume  in  VOL_W  unsigned gain, FRAC fractional bits (1.0 = 1<<FRAC)
- osc_index  out  $clog2(N_OSC)  oscillator select
- out  out  WIDTH+FRAC  signed mixed sample, held between updates
- out_valid  out  1  one-cycle pulse when out updates
- clip  out  1  sticky saturation flag
- overrun  out  1  sticky flag: frame_start received while busy
- num_active  out  $clog2(N_OSC)+1  enabled oscillators counted in the last frame

Behaviour:
- Reset (async, rstn=0) values:
  - osc_index=0, out=0, out_valid=0, clip=0, overrun=0, num_active=0.
  - Accumulator=0, state=IDLE.
- Accumulator width: WIDTH+FRAC+$clog2(N_OSC)+1 signed; wave_in is sign-extended before adding, so the sum never overflows.
- State machine:
  - IDLE: osc_index=0. On frame_start: clear accumulator and active count, go to SWEEP.
  - SWEEP: osc_index advances by 1 each cycle, from 0 through N_OSC-1, then holds at N_OSC-1.
    - Wave for index i is sampled exactly OSC_LATENCY cycles after osc_index=i was driven.
    - Sampled wave is added to the accumulator only if osc_enable[i] is 1 at sampling time; the active count increments likewise.
    - After the last (index N_OSC-1) sample is taken, go to SCALE.
    - SWEEP lasts N_OSC+OSC_LATENCY cycles.
  - SCALE: one cycle; product = accumulator * {1'b0, master_volume} (signed), registered. Go to SAT.
  - SAT: one cycle.
    - shifted = product >>> FRAC (arithmetic).
    - If shifted > 2^(WIDTH+FRAC-1)-1 or < -2^(WIDTH+FRAC-1): clamp to that bound and set clip.
    - Register out, pulse out_valid, load num_active. Go to IDLE.
- Latency: out_valid asserts N_OSC+OSC_LATENCY+2 cycles after the frame_start cycle.
- frame_start outside IDLE: ignored (current frame completes normally) and overrun set.
- frame_start in the same cycle that SAT returns to IDLE: ignored and flagged, because the state is not yet IDLE.
- clip and overrun clear only on reset.
- osc_enable and master_volume are not latched; they are sampled live as specified above.
- Reset mid-frame: immediate return to reset values; no out_valid is produced for the aborted frame.
- master_volume=0: out=0 with no clip. master_volume=1<<FRAC: out equals the sum, saturated.

Test Plan:
- Unity gain, all enabled: N_OSC=16, OSC_LATENCY=1, every wave_in=1000<<8, volume=256, one frame_start -> out=16000<<8, num_active=16, out_valid 19 cycles after frame_start, osc_index sequence 0..15 observed.
- Mask/sign: enable only osc 0 and 5, wave_in=+5000<<8 at idx0 and -2000<<8 at idx5, others 7777 -> out=3000<<8, num_active=2.
- Saturation: all 16 waves = (2^31-1), volume=256 -> out=2^31-1, clip=1; repeat with -2^31 -> out=-2^31, clip stays 1.
- Volume scaling: sum=4096<<8, volume=128 -> out=2048<<8; volume=0 -> out=0, clip unchanged.
- Overrun: second frame_start 5 cycles after the first -> single out_valid at cycle 19 with first frame's sum, overrun=1.
- Async reset: assert rstn=0 at SWEEP cycle 7, release, issue a new frame -> outputs zero immediately on reset, no out_valid until new frame completes, correct new sum.
